fp16_add_seq: RTL

FP16_ADD_SEQ -- requirements
Module: fp16_add_seq

---
 rtl/fp16_add_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fp16_add_seq.sv
// Sequential half-precision adder: one operation in flight, multi-cycle
// align/normalise, truncation rounding, denormals flushed to zero.
module fp16_add_seq #(
  parameter bit SAT_INF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, PACK, OUT
  } state_t;

  state_t state, nstate;

  logic [4:0]  ea, eb;
  logic [10:0] ma, mb;
  logic        a_nan, b_nan;
  logic        a_inf, b_inf;
  logic        spec_in, a_big;
  logic [15:0] spec_val;

  logic        sx, sub, spec;
  logic [4:0]  ex, d;
  logic [11:0] mx;
  logic [10:0] my;
  logic [15:0] sval;

  assign ea = a[14:10];
  assign eb = b[14:10];
  assign ma = (ea != 5'd0) ? {1'b1, a[9:0]} : 11'd0;
  assign mb = (eb != 5'd0) ? {1'b1, b[9:0]} : 11'd0;

  assign a_nan = (&ea) & (|a[9:0]);
  assign b_nan = (&eb) & (|b[9:0]);
  assign a_inf = (&ea) & ~(|a[9:0]);
  assign b_inf = (&eb) & ~(|b[9:0]);
  assign spec_in = (&ea) | (&eb);

  // inf - inf and any NaN collapse to the canonical quiet NaN
  always_comb begin
    spec_val = b;
    if (a_nan | b_nan | (a_inf & b_inf & (a[15] ^ b[15])))
      spec_val = 16'h7E00;
    else if (a_inf)
      spec_val = a;
  end

  assign a_big = {ea, ma} >= {eb, mb};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (in_valid) nstate = spec_in ? PACK : ALIGN;
      ALIGN: if (d == 5'd0) nstate = ADD;
      ADD:   nstate = NORM;
      NORM: begin
        if (mx[11])
          nstate = NORM;
        else if (mx == 12'd0)
          nstate = PACK;
        else if (!mx[10])
          nstate = (ex == 5'd1) ? PACK : NORM;
        else
          nstate = PACK;
      end
      PACK:  nstate = OUT;
      OUT:   if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx       <= 1'b0;
      sub      <= 1'b0;
      spec     <= 1'b0;
      ex       <= 5'd0;
      d        <= 5'd0;
      mx       <= 12'd0;
      my       <= 11'd0;
      sval     <= 16'h0000;
      result   <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sub  <= a[15] ^ b[15];
          spec <= spec_in;
          sval <= spec_val;
          if (a_big) begin
            sx <= a[15];
            ex <= ea;
            mx <= {1'b0, ma};
            my <= mb;
            d  <= ea - eb;
          end else begin
            sx <= b[15];
            ex <= eb;
            mx <= {1'b0, mb};
            my <= ma;
            d  <= eb - ea;
          end
        end
        ALIGN: begin
          if (d >= 5'd12) begin
            my <= 11'd0;
            d  <= 5'd0;
          end else if (d != 5'd0) begin
            my <= my >> 1;
            d  <= d - 5'd1;
          end
        end
        ADD: begin
          if (sub) mx <= mx - {1'b0, my};
          else     mx <= mx + {1'b0, my};
        end
        NORM: begin
          if (mx[11]) begin
            mx <= mx >> 1;
            ex <= ex + 5'd1;
          end else if (mx == 12'd0) begin
            sx <= 1'b0;
            ex <= 5'd0;
          end else if (!mx[10]) begin
            // below the smallest normal: flush instead of going denormal
            if (ex == 5'd1) begin
              sx <= 1'b0;
              ex <= 5'd0;
              mx <= 12'd0;
            end else begin
              mx <= mx << 1;
              ex <= ex - 5'd1;
            end
          end
        end
        PACK: begin
          if (spec) begin
            result   <= sval;
            overflow <= 1'b0;
          end else if (ex == 5'd31) begin
            result   <= {sx, SAT_INF ? 15'h7C00 : 15'h7BFF};
            overflow <= 1'b1;
          end else begin
            result   <= {sx, ex, mx[9:0]};
            overflow <= 1'b0;
          end
        end
        OUT: ;
        default: ;
      endcase
    end
  end

endmodule
